fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the RV32I core. Owns the program counter and issues word requests to instruction memory over a request/grant/response-valid interface. Buffers returned words, each tagged with its PC, in a small flushable FIFO. Presents them to the decode stage over a valid/ready handshake; decode feeds the instruction word to the immediate extender and the control decoder. Handles control-flow redirects by flushing buffered words and discarding in-flight responses.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- FIFO_DEPTH, 2, instruction buffer entries (≥2); also the cap on outstanding requests plus buffered words

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  word address of request (= fetch PC)
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  response valid; in order, one per granted request, ≥1 cycle after grant
- imem_rdata_i  in  32  instruction word
- redirect_i  in  1  branch/jump taken; flush and refetch
- redirect_pc_i  in  32  new PC
- inst_valid_o  out  1  buffer head valid
- inst_ready_i  in  1  decode accepts head
- inst_o  out  32  instruction word
- pc_o  out  32  PC of inst_o
- misalign_o  out  1  head is a misaligned-target fault marker

## Operation
- Reset values: imem_req_o 0, fetch_pc = RESET_PC, resp_pc = RESET_PC, outstanding = 0, discard = 0, FIFO empty, inst_valid_o 0, inst_o/pc_o 0, misalign_o 0.
- Credit: imem_req_o = !redirect_i && !halted && (outstanding + occupancy − pop) < FIFO_DEPTH, where pop = inst_valid_o && inst_ready_i. The ready→req combinational path is intended.
- An un-granted request carries no commitment; the address may change and req may drop.
- On req && gnt: fetch_pc += 4 (wraps mod 2^32); outstanding += 1.
- On rvalid: outstanding −= 1. If discard > 0, the word is dropped and discard −= 1. Otherwise {resp_pc, rdata, 0} is pushed and resp_pc += 4.
- Overflow is impossible by the credit rule. An attempted push into a full FIFO is an assertion failure.
- Pop on inst_valid_o && inst_ready_i. Outputs show the head entry; they are held stable while valid && !ready.
- Redirect (highest priority):
  - FIFO flushed; no pop that cycle.
  - fetch_pc and resp_pc ← redirect_pc_i.
  - discard ← outstanding after this cycle's rvalid/gnt updates, i.e. all in-flight responses, including one granted in this same cycle.
  - imem_req_o forced 0 that cycle.
- Back-to-back redirects: the last one wins; discard accumulates correctly.
- Counters are sized to hold FIFO_DEPTH.

## Timing
- Redirect takes effect on the next edge; first request to the new PC is the following cycle.
- With a memory that grants in the same cycle and responds the next cycle:
  - gnt at cycle N, rvalid at N+1, inst_valid_o at N+2.
  - Redirect at cycle R: request to the new PC at R+1, inst_valid_o for it at R+3.
- Sustained throughput is 1 instruction/cycle at FIFO_DEPTH=2 with 1-cycle memory latency and decode always ready.
- Reset may assert mid-transaction. All state clears immediately. Responses to pre-reset requests are the memory's responsibility to squash.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect with redirect_pc_i[1:0] ≠ 0 sets halted.
  - Once outstanding responses are discarded, it pushes one entry {redirect_pc_i, 32'h0, misalign=1}.
  - No further requests until the next redirect, which clears halted.
- Not defined: redirect_pc_i[1:0] is forced to 2'b00, halted never sets, misalign_o is tied 0.

## Structure
- fetch_pkg holds:
  - fetch_entry_t struct {pc[31:0], inst[31:0], misalign}
  - DEFAULT_RESET_PC
  - PC_STEP = 4
- One sub-module, fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush, full, empty and count outputs.
  - Flush has priority over push and pop.
  - First-word output is read combinationally from the head register.

## Test plan
- Reset release, 1-cycle memory, ready=1 → addresses 0x0, 0x4, 0x8… on consecutive cycles; inst_valid_o first high 2 cycles after first gnt; pc_o tracks 0x0, 0x4…
- inst_ready_i=0 for 10 cycles → at most FIFO_DEPTH requests granted; outputs stable; no push on a full FIFO; streaming resumes at the next address.
- Redirect to 0x100 with 2 requests in flight and gnt in the same cycle → 2 responses dropped; next inst_o carries pc_o=0x100.
- Memory with 3-cycle latency and random gnt stalls → in-order, gap-free pc_o sequence; address held correct on each granted cycle.
- Back-to-back redirects to 0x200 then 0x300 → no output with pc 0x200; first output pc_o=0x300.
- FETCH_ALIGN_CHECK_EN set, redirect to 0x102 → single entry with misalign_o=1, pc_o=0x102, inst_o=0; no requests until a redirect to 0x200 restarts fetch.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
package fetch_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        misalign;
    } fetch_entry_t;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: flushable synchronous FIFO of PC-tagged instruction words; head read combinationally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  din,
    output fetch_entry_t  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !flush))
        else $error("fetch_fifo: push into full FIFO");
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch stage - PC, credit-limited imem requests, tagged instruction buffer, redirect flush.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect targets halt fetch and emit one fault marker entry.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        misalign_o
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]   fetch_pc, resp_pc, target;
    logic [CW-1:0] outstanding, outstanding_nx, discard, count;
    logic          pop, push, push_data, drop, marker, halted, empty, unused_full;
    fetch_entry_t  head, entry;

    // Credit counts in-flight requests plus buffered words so a response always has a slot.
    assign pop        = inst_valid_o && inst_ready_i;
    assign imem_req_o = rst_n && !redirect_i && !halted &&
                        (({1'b0, outstanding} + {1'b0, count} - {{CW{1'b0}}, pop}) < (CW + 1)'(FIFO_DEPTH));
    assign imem_addr_o    = fetch_pc;
    assign outstanding_nx = outstanding + CW'(imem_req_o && imem_gnt_i) - CW'(imem_rvalid_i);
    assign drop           = imem_rvalid_i && discard != '0;
    assign push_data      = imem_rvalid_i && discard == '0;
    assign push           = push_data || marker;
    assign entry          = marker ? fetch_entry_t'{pc: fetch_pc, inst: 32'h0, misalign: 1'b1}
                                   : fetch_entry_t'{pc: resp_pc, inst: imem_rdata_i, misalign: 1'b0};
    assign inst_valid_o   = !empty;
    assign inst_o         = head.inst;
    assign pc_o           = head.pc;

`ifdef FETCH_ALIGN_CHECK_EN
    logic pend;
    assign target     = redirect_pc_i;
    assign marker     = pend && outstanding == '0 && !redirect_i;
    assign misalign_o = head.misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted <= 1'b0;
            pend   <= 1'b0;
        end else if (redirect_i) begin
            halted <= |redirect_pc_i[1:0];
            pend   <= |redirect_pc_i[1:0];
        end else if (marker) begin
            pend <= 1'b0;
        end
    end
`else
    logic unused_misalign;
    assign target          = redirect_pc_i & ~32'h3;
    assign marker          = 1'b0;
    assign halted          = 1'b0;
    assign misalign_o      = 1'b0;
    assign unused_misalign = head.misalign;
`endif

    // A redirect discards every response still owed, including one granted this very cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_nx;
            if (redirect_i) begin
                fetch_pc <= target;
                resp_pc  <= target;
                discard  <= outstanding_nx;
            end else begin
                if (imem_req_o && imem_gnt_i) fetch_pc <= fetch_pc + PC_STEP;
                if (push_data) resp_pc <= resp_pc + PC_STEP;
                if (drop) discard <= discard - CW'(1);
            end
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_i),
        .din   (entry),
        .dout  (head),
        .full  (unused_full),
        .empty (empty),
        .count (count)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit with a latency/grant-configurable memory model.
`timescale 1ns/1ps
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 0, rst_n = 0;
    logic        imem_req_o, imem_gnt_i = 0, imem_rvalid_i = 0;
    logic [31:0] imem_addr_o, imem_rdata_i = 0;
    logic        redirect_i = 0, inst_ready_i = 0;
    logic [31:0] redirect_pc_i = 0, inst_o, pc_o;
    logic        inst_valid_o, misalign_o;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } mreq_t;

    int           checks = 0, errors = 0, cyc = 0, consumed = 0, grants = 0, lat = 1;
    int           t_ref = 0, t_gnt = -1, t_val = -1, first_acc = 0, last_acc = 0, g0 = 0;
    bit           rnd_gnt = 0, hold = 0;
    logic [31:0]  exp_addr = 0, hold_pc = 0, hold_inst = 0;
    fetch_entry_t exp_q[$];
    fetch_entry_t mon_e, drv_e;
    mreq_t        mem_q[$];
    mreq_t        m_req;

    fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .inst_valid_o  (inst_valid_o),
        .inst_ready_i  (inst_ready_i),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .misalign_o    (misalign_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic logic [31:0] tgt(input logic [31:0] a);
`ifdef FETCH_ALIGN_CHECK_EN
        return a;
`else
        return a & ~32'h3;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_run(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            drv_e.pc       = base + 32'(4 * i);
            drv_e.inst     = inst_of(drv_e.pc);
            drv_e.misalign = 1'b0;
            exp_q.push_back(drv_e);
        end
    endtask

    task automatic wait_consumed(input int target, input int budget);
        int k = 0;
        while (consumed < target && k < budget) begin
            step();
            k++;
        end
        inst_ready_i = 0;
        check("consumed_count", 32'(consumed), 32'(target));
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_i    = 1;
        redirect_pc_i = pc;
        step();
        redirect_i    = 0;
    endtask

    // Memory: records each handshake with its due cycle, answers in order one per cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_q.delete();
            exp_addr = 32'h0;
        end else if (redirect_i) begin
            check("req_during_redirect", {31'b0, imem_req_o}, 32'd0);
            exp_addr = tgt(redirect_pc_i);
        end else if (imem_req_o && imem_gnt_i) begin
            check("grant_addr", imem_addr_o, exp_addr);
            exp_addr   = exp_addr + 32'd4;
            m_req.due  = cyc + lat;
            m_req.addr = imem_addr_o;
            mem_q.push_back(m_req);
            grants++;
            if (t_gnt < 0 && cyc >= t_ref) t_gnt = cyc;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        imem_gnt_i = rnd_gnt ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rvalid_i = 1;
            imem_rdata_i  = inst_of(mem_q[0].addr);
            mem_q.delete(0);
        end else begin
            imem_rvalid_i = 0;
            imem_rdata_i  = 32'h0;
        end
    end

    // Monitor: pops the scoreboard on every accepted instruction, checks hold stability.
    always @(negedge clk) begin
        if (hold) begin
            check("hold_valid", {31'b0, inst_valid_o}, 32'd1);
            check("hold_pc", pc_o, hold_pc);
            check("hold_inst", inst_o, hold_inst);
        end
        hold      = rst_n && inst_valid_o && !inst_ready_i && !redirect_i;
        hold_pc   = pc_o;
        hold_inst = inst_o;
        if (rst_n && t_val < 0 && cyc >= t_ref && inst_valid_o) t_val = cyc;
        if (rst_n && inst_valid_o && inst_ready_i && !redirect_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got pc 0x%08h, required no output", pc_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_pc", pc_o, mon_e.pc);
                check("out_inst", inst_o, mon_e.inst);
                check("out_misalign", {31'b0, misalign_o}, {31'b0, mon_e.misalign});
            end
            if (consumed == 0) first_acc = cyc;
            last_acc = cyc;
            consumed++;
        end
    end

    initial begin
        step(3);
        check("rst_req", {31'b0, imem_req_o}, 32'd0);
        check("rst_valid", {31'b0, inst_valid_o}, 32'd0);
        check("rst_inst", inst_o, 32'd0);
        check("rst_pc", pc_o, 32'd0);
        check("rst_misalign", {31'b0, misalign_o}, 32'd0);
        check("rst_addr", imem_addr_o, 32'd0);

        // Streaming from reset, 1-cycle memory.
        expect_run(32'h0, 8);
        rst_n = 1;
        t_ref = cyc;
        inst_ready_i = 1;
        wait_consumed(8, 40);
        check("first_gnt_cycle", 32'(t_gnt), 32'(t_ref));
        check("first_valid_latency", 32'(t_val - t_gnt), 32'd2);
        check("stream_throughput", 32'(last_acc - first_acc), 32'd7);

        // Decode stall for 10 cycles.
        g0 = grants;
        step(10);
        check("stall_grants_le_depth", {31'b0, (grants - g0) <= 2}, 32'd1);
        check("stall_head_pc", pc_o, 32'h20);
        check("stall_head_inst", inst_o, inst_of(32'h20));
        expect_run(32'h20, 8);
        inst_ready_i = 1;
        wait_consumed(16, 40);

        // Redirect with two requests in flight on a 3-cycle memory.
        lat = 3;
        redirect(32'h80);
        step(2);
        check("inflight_at_redirect", 32'(mem_q.size()), 32'd2);
        redirect(32'h100);
        expect_run(32'h100, 8);
        inst_ready_i = 1;
        wait_consumed(24, 80);

        // Random grant stalls, 3-cycle memory.
        rnd_gnt = 1;
        redirect(32'h400);
        expect_run(32'h400, 12);
        inst_ready_i = 1;
        wait_consumed(36, 400);
        rnd_gnt = 0;
        step(10);

        // Back-to-back redirects, 1-cycle memory.
        lat = 1;
        redirect_i    = 1;
        redirect_pc_i = 32'h200;
        step();
        redirect_pc_i = 32'h300;
        t_ref = cyc + 1;
        t_gnt = -1;
        t_val = -1;
        step();
        redirect_i = 0;
        expect_run(32'h300, 8);
        inst_ready_i = 1;
        wait_consumed(44, 60);
        check("redirect_first_req", 32'(t_gnt), 32'(t_ref));
        check("redirect_first_valid", 32'(t_val), 32'(t_ref + 2));
        step(5);

        // Misaligned redirect target.
`ifdef FETCH_ALIGN_CHECK_EN
        redirect(32'h102);
        drv_e.pc       = 32'h102;
        drv_e.inst     = 32'h0;
        drv_e.misalign = 1'b1;
        exp_q.push_back(drv_e);
        inst_ready_i = 1;
        wait_consumed(45, 20);
        g0 = grants;
        step(8);
        check("halted_grants", 32'(grants - g0), 32'd0);
        check("halted_valid", {31'b0, inst_valid_o}, 32'd0);
        redirect(32'h200);
        expect_run(32'h200, 4);
        inst_ready_i = 1;
        wait_consumed(49, 30);
`else
        redirect(32'h102);
        expect_run(32'h100, 4);
        inst_ready_i = 1;
        wait_consumed(48, 30);
`endif
        step(2);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
